// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU core (master 0,
// fixed priority) and a secondary requester (master 1). A saturating wait
// counter bounds how long master 1 can be starved, and a one-entry response
// tracker steers each read result back to the master that issued the read.
// STARVE_LIMIT must be at least 1.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,

  input  logic        m0_req_i,
  input  logic [3:0]  m0_wstrb_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  input  logic [3:0]  m1_wstrb_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,

  output logic        mem_enable_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wvalue_o,
  input  logic [31:0] mem_rvalue_i
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt;   // consecutive cycles master 1 has lost
  logic             rd_pending; // a read was granted last cycle
  logic             rd_owner;   // which master issued that read (0 or 1)

  logic m1_starved;
  logic m0_win;
  logic m1_win;

  // Arbitration: master 0 wins ties unless master 1 has waited the limit.
  // The grant is masked while reset is held so nothing leaks out during reset.
  always_comb begin
    m1_starved = (wait_cnt == CNT_MAX);
    m1_win     = rstn_i & m1_req_i & (~m0_req_i | m1_starved);
    m0_win     = rstn_i & m0_req_i & ~m1_win;
  end

  assign m0_gnt_o = m0_win;
  assign m1_gnt_o = m1_win;

  // Memory port mux: the granted master drives the port, otherwise all zero.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    mem_enable_o = 1'b0;
    mem_wstrb_o  = '0;
    mem_addr_o   = '0;
    mem_wvalue_o = '0;
    if (m1_win) begin
      mem_enable_o = 1'b1;
      mem_wstrb_o  = m1_wstrb_i;
      mem_addr_o   = m1_addr_i;
      mem_wvalue_o = m1_wdata_i;
    end else if (m0_win) begin
      mem_enable_o = 1'b1;
      mem_wstrb_o  = m0_wstrb_i;
      mem_addr_o   = m0_addr_i;
      mem_wvalue_o = m0_wdata_i;
    end
  end

  // Starvation counter: counts master 1's consecutive lost cycles, saturating.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order. Reset is asynchronous
    // and clears all state immediately.
    if (!rstn_i) begin
      wait_cnt <= '0;
    end else if (!m1_req_i || m1_win) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_MAX) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Response tracker: remembers whether this cycle's access is a read and who
  // issued it, so the data returned next cycle reaches the right master.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      rd_pending <= mem_enable_o & (mem_wstrb_o == 4'b0000);
      rd_owner   <= m1_win;
    end
  end

  // Response demux: read data is zero for the master that is not being answered.
  always_comb begin
    m0_rvalid_o = rstn_i & rd_pending & ~rd_owner;
    m1_rvalid_o = rstn_i & rd_pending &  rd_owner;
    m0_rdata_o  = m0_rvalid_o ? mem_rvalue_i : '0;
    m1_rdata_o  = m1_rvalid_o ? mem_rvalue_i : '0;
  end

endmodule
